// File: rtl/fwft_arb_pkg.sv
// Shared types and helpers for the packet-locked FIFO write-port arbiter.
package fwft_arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   // Index width that never collapses to zero for tiny requester counts.
   function automatic int clog2_min1(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
module rr_pick
   import fwft_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W:0]   start;
   logic [IDX_W:0]   sel;
   logic [IDX_W:0]   wrapped;
   logic [NUM_REQ-1:0] rot;

   // Rotate so bit 0 is the requester after ptr, then priority-encode the lowest set bit.
   always_comb begin
      start   = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
      rot     = NUM_REQ'({req, req} >> start);
      found   = |rot;
      sel     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sel = rot[i] ? (IDX_W+1)'(i) : sel;
      end
      wrapped = start + sel;
      idx     = IDX_W'((wrapped >= (IDX_W+1)'(NUM_REQ)) ? (wrapped - (IDX_W+1)'(NUM_REQ)) : wrapped);
   end

endmodule

// File: rtl/fwft_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module fwft_wr_arbiter
   import fwft_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = clog2_min1(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   input  logic                          fifo_full,
   output logic                          busy,
   output logic [IDX_W-1:0]              grant_idx
);

   arb_state_t            state;
   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;
   logic [DATA_WIDTH-1:0] g_data;

   // grant_idx doubles as the round-robin pointer: both always hold the last pick.
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (grant_idx),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Write-port steering: only the granted requester sees ready, and only while the FIFO has room.
   always_comb begin
      req_ready    = '0;
      fifo_wr      = 1'b0;
      fifo_wr_data = '0;
      g_data       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         g_data = (IDX_W'(i) == grant_idx) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : g_data;
      end
      if (state == BUSY) begin
         req_ready[grant_idx] = !fifo_full;
         fifo_wr              = req_valid[grant_idx] & !fifo_full;
      end else begin
         req_ready = '0;
         fifo_wr   = 1'b0;
      end
      if (fifo_wr) begin
         fifo_wr_data = g_data;
      end else begin
         fifo_wr_data = '0;
      end
   end

   // Grant FSM: arbitrate in IDLE, hold the grant until the last beat of the packet is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_idx <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (fifo_wr && req_last[grant_idx]) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == BUSY);

endmodule

// File: tb/tb_fwft_wr_arbiter.sv
// Directed scoreboard bench for fwft_wr_arbiter: expected FIFO beats are queued as packets are offered.
module tb_fwft_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_wr;
   logic [DW-1:0]   fifo_wr_data;
   logic            fifo_full = 1'b0;
   logic            busy;
   logic [IW-1:0]   grant_idx;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         rq [N][$];
   logic [DW-1:0] exp_q[$];
   int            grant_log[$];

   int            total = 0;
   int            bad = 0;
   logic [N-1:0]  acc_s = '0;
   logic          busy_prev = 1'b0;
   int            ncyc = 0;
   int            wr_cnt = 0;
   int            wr_first = 0;
   int            wr_last = 0;
   int            wr_per[N];
   logic [DW-1:0] mon_e;

   fwft_wr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr      (fifo_wr),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .busy         (busy),
      .grant_idx    (grant_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      for (int r = 0; r < N; r++) begin
         if (rq[r].size() > 0) begin
            req_valid[r]          = 1'b1;
            req_last[r]           = rq[r][0].last;
            req_data[r*DW +: DW]  = rq[r][0].data;
         end else begin
            req_valid[r]          = 1'b0;
            req_last[r]           = 1'b0;
            req_data[r*DW +: DW]  = '0;
         end
      end
   endtask

   // Advance one clock; beats handshaken in the cycle just ended leave their producer queue.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
         if (acc_s[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      end
      drive();
   endtask

   task automatic add_pkt(input int r, input int n, input int base);
      logic [DW-1:0] d;
      for (int b = 0; b < n; b++) begin
         d = {8'(r), 8'(base), 16'(b)};
         rq[r].push_back({(b == n - 1), d});
         exp_q.push_back(d);
      end
   endtask

   task automatic clear_all();
      for (int r = 0; r < N; r++) rq[r].delete();
      exp_q.delete();
      drive();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      logic pend;
      n = 0;
      pend = 1'b1;
      while (pend && n < budget) begin
         tick();
         n++;
         pend = (exp_q.size() != 0);
         for (int r = 0; r < N; r++) pend = pend | (rq[r].size() != 0);
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Output monitor: scoreboard compare of every FIFO write plus grant logging.
   always @(negedge clk) begin
      acc_s = req_valid & req_ready;
      ncyc++;
      if (!rst) begin
         if (busy && !busy_prev) grant_log.push_back(int'(grant_idx));
         if (fifo_wr) begin
            chk("wr_while_full", 32'(fifo_full), 32'd0);
            total++;
            assert (exp_q.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_wr observed=%0h expected=none", fifo_wr_data);
            end
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("wr_data", fifo_wr_data, mon_e);
            end
            wr_cnt++;
            wr_per[fifo_wr_data[25:24]]++;
            if (wr_cnt == 1) wr_first = ncyc;
            wr_last = ncyc;
         end else begin
            chk("idle_data_zero", fifo_wr_data, 32'd0);
         end
      end
      busy_prev = busy;
   end

   initial begin
      for (int r = 0; r < N; r++) wr_per[r] = 0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_idx), 32'd3);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr", 32'(fifo_wr), 32'd0);
      chk("rst_data", fifo_wr_data, 32'd0);
      tick();

      // Single 3-beat packet from requester 2
      add_pkt(2, 3, 1);
      tick();
      @(negedge clk);
      chk("t1_arb_busy", 32'(busy), 32'd0);
      chk("t1_arb_wr", 32'(fifo_wr), 32'd0);
      chk("t1_arb_ready", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_grant", 32'(grant_idx), 32'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_wr0", 32'(fifo_wr), 32'd1);
      chk("t1_ready", 32'(req_ready), 32'b0100);
      tick();
      @(negedge clk);
      chk("t1_wr1", 32'(fifo_wr), 32'd1);
      tick();
      @(negedge clk);
      chk("t1_wr2", 32'(fifo_wr), 32'd1);
      tick();
      @(negedge clk);
      chk("t1_done_busy", 32'(busy), 32'd0);
      chk("t1_done_wr", 32'(fifo_wr), 32'd0);
      chk("t1_drained", 32'(exp_q.size()), 32'd0);
      tick();

      // Three simultaneous 2-beat packets after reset: order R0, R1, R3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_all();
      grant_log.delete();
      add_pkt(0, 2, 2);
      add_pkt(1, 2, 3);
      add_pkt(3, 2, 4);
      wait_drain("t2_drain", 60);
      chk("t2_ngrant", 32'(grant_log.size()), 32'd3);
      if (grant_log.size() >= 3) begin
         chk("t2_g0", 32'(grant_log[0]), 32'd0);
         chk("t2_g1", 32'(grant_log[1]), 32'd1);
         chk("t2_g2", 32'(grant_log[2]), 32'd3);
      end

      // R0 raises valid while R1 is mid-packet: R1 finishes first
      grant_log.delete();
      add_pkt(1, 4, 5);
      tick();
      tick();
      tick();
      add_pkt(0, 2, 6);
      wait_drain("t3_drain", 60);
      chk("t3_ngrant", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() >= 2) begin
         chk("t3_g0", 32'(grant_log[0]), 32'd1);
         chk("t3_g1", 32'(grant_log[1]), 32'd0);
      end

      // FIFO full for 5 cycles during R0 beat 1
      wr_cnt = 0;
      add_pkt(0, 3, 7);
      tick();
      tick();
      @(negedge clk);
      chk("t4_b0_wr", 32'(fifo_wr), 32'd1);
      tick();
      fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_full_ready", 32'(req_ready), 32'd0);
         chk("t4_full_wr", 32'(fifo_wr), 32'd0);
         chk("t4_full_busy", 32'(busy), 32'd1);
         tick();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      chk("t4_b1_wr", 32'(fifo_wr), 32'd1);
      wait_drain("t4_drain", 40);
      chk("t4_wr_count", 32'(wr_cnt), 32'd3);

      // Reset mid-packet of R3, then R0 and R3 compete
      add_pkt(3, 4, 8);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_all();
      add_pkt(0, 1, 9);
      add_pkt(3, 1, 10);
      drive();
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_ready", 32'(req_ready), 32'd0);
      chk("t5_grant", 32'(grant_idx), 32'd3);
      chk("t5_wr", 32'(fifo_wr), 32'd0);
      tick();
      @(negedge clk);
      chk("t5_regrant", 32'(grant_idx), 32'd0);
      wait_drain("t5_drain", 40);

      // 16 single-beat packets, all requesters continuously valid
      grant_log.delete();
      wr_cnt = 0;
      for (int r = 0; r < N; r++) wr_per[r] = 0;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < N; r++) add_pkt(r, 1, 16 + k);
      end
      wait_drain("t6_drain", 100);
      chk("t6_wr_count", 32'(wr_cnt), 32'd16);
      chk("t6_span", 32'(wr_last - wr_first), 32'd30);
      for (int r = 0; r < N; r++) chk("t6_per_req", 32'(wr_per[r]), 32'd4);
      chk("t6_ngrant", 32'(grant_log.size()), 32'd16);
      for (int i = 0; i < grant_log.size(); i++) begin
         chk("t6_rotation", 32'(grant_log[i]), 32'(i % 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
